// File: rtl/lc3_mem_arbiter.sv
// Shares the single LC-3 memory port between the CPU datapath and the program loader.
// Each access takes MEM_LAT enable cycles and is followed by a one-cycle completion pulse.
module lc3_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              r_bit,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              owner
);

    localparam int          CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                last_q,      last_d;
    logic                owner_q,     owner_d;
    logic                busy_q,      busy_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
    logic                r_bit_q,     r_bit_d;
    logic                ldr_ack_q,   ldr_ack_d;

    // Loader wins when it is the only requester, or on a tie when the CPU was served last.
    logic grant_ldr;
    assign grant_ldr = ldr_req & (~cpu_req | ~last_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        r_bit_d     = 1'b0;
        ldr_ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req | ldr_req) begin
                    state_d     = ST_ACCESS;
                    cnt_d       = LAT_M1;
                    last_d      = grant_ldr;
                    owner_d     = grant_ldr;
                    busy_d      = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = grant_ldr ? ldr_we    : cpu_we;
                    mem_addr_d  = grant_ldr ? ldr_addr  : cpu_addr;
                    mem_wdata_d = grant_ldr ? ldr_wdata : cpu_wdata;
                end
            end

            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d  = ST_DONE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!mem_we_q) begin
                        if (owner_q) begin
                            ldr_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                    r_bit_d   = ~owner_q;
                    ldr_ack_d = owner_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            // Requests are deliberately not sampled here so a held MIO_EN is not re-granted.
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            r_bit_q     <= 1'b0;
            ldr_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            r_bit_q     <= r_bit_d;
            ldr_ack_q   <= ldr_ack_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;
    assign r_bit     = r_bit_q;
    assign ldr_ack   = ldr_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: transaction-timeline reference model, directed scenarios and random traffic.
module tb_lc3_mem_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int MEM_LAT = 3;

    logic              clk;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              r_bit;
    logic              ldr_req, ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata, ldr_rdata;
    logic              ldr_ack;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy, owner;

    lc3_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .r_bit(r_bit),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_val(input int i);
        if (i == 0) return 16'h1234;
        return DATA_W'(i * 257) ^ 16'hA5A5;
    endfunction

    // Memory device seen by the DUT (256 words, indexed by low address byte).
    logic [DATA_W-1:0] dev_mem [256];
    assign mem_rdata = dev_mem[mem_addr[7:0]];

    initial begin
        for (int i = 0; i < 256; i++) dev_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (reset && mem_en && mem_we) dev_mem[mem_addr[7:0]] = mem_wdata;
        end
    end

    // Reference model: a transaction is described by its owner, fields and age m_t in cycles
    // since grant; ages 1..MEM_LAT drive memory, age MEM_LAT+1 is the completion pulse.
    logic [DATA_W-1:0] model_mem [256];
    bit                m_active;
    int                m_t;
    bit                m_last;
    bit                m_owner;
    bit                m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] e_cpu_rdata, e_ldr_rdata;

    task automatic model_reset();
        m_active = 0; m_t = 0; m_last = 1; m_owner = 0;
        m_we = 0; m_addr = '0; m_wdata = '0;
        e_cpu_rdata = '0; e_ldr_rdata = '0;
    endtask

    initial begin
        bit g;
        for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                model_reset();
            end else if (m_active) begin
                if (m_t == MEM_LAT) begin
                    if (m_we) model_mem[m_addr[7:0]] = m_wdata;
                    else if (m_owner) e_ldr_rdata = model_mem[m_addr[7:0]];
                    else e_cpu_rdata = model_mem[m_addr[7:0]];
                    m_t++;
                end else if (m_t == MEM_LAT + 1) begin
                    m_active = 0;
                    m_t = 0;
                end else begin
                    m_t++;
                end
            end else if (cpu_req || ldr_req) begin
                g = (cpu_req && ldr_req) ? !m_last : ldr_req;
                m_last = g; m_owner = g;
                m_we    = g ? ldr_we    : cpu_we;
                m_addr  = g ? ldr_addr  : cpu_addr;
                m_wdata = g ? ldr_wdata : cpu_wdata;
                m_active = 1; m_t = 1;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    bit run_cmp = 1'b1;
    initial begin
        bit e_en, e_pulse;
        forever begin
            @(negedge clk);
            if (run_cmp) begin
                e_en    = m_active && (m_t >= 1) && (m_t <= MEM_LAT);
                e_pulse = m_active && (m_t == MEM_LAT + 1);
                check("m_mem_en",    32'(mem_en),  32'(e_en));
                check("m_mem_we",    32'(mem_we),  32'(e_en && m_we));
                check("m_busy",      32'(busy),    32'(m_active));
                check("m_owner",     32'(owner),   32'(m_owner));
                check("m_r_bit",     32'(r_bit),   32'(e_pulse && !m_owner));
                check("m_ldr_ack",   32'(ldr_ack), 32'(e_pulse && m_owner));
                check("m_cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rdata));
                check("m_ldr_rdata", 32'(ldr_rdata), 32'(e_ldr_rdata));
                if (e_en) begin
                    check("m_mem_addr", 32'(mem_addr), 32'(m_addr));
                    if (m_we) check("m_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_ldr_rdata", 32'(ldr_rdata), 0);
        @(posedge clk);
        next_cycle();
        reset = 1'b1;

        // CPU read of 0x3000, request held through the R cycle
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) cpu_req = 0;
            @(negedge clk);
            check("t1_mem_en", 32'(mem_en), 32'(c >= 1 && c <= 3));
            check("t1_r_bit", 32'(r_bit), 32'(c == 4));
            if (c >= 1 && c <= 3) check("t1_mem_addr", 32'(mem_addr), 32'h3000);
            next_cycle();
        end
        check("t1_cpu_rdata", 32'(cpu_rdata), 32'h1234);
        check("t1_owner", 32'(owner), 0);

        // Loader write of 0xBEEF to 0x3005
        ldr_req = 1; ldr_we = 1; ldr_addr = 16'h3005; ldr_wdata = 16'hBEEF;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) ldr_req = 0;
            @(negedge clk);
            check("t2_mem_we", 32'(mem_we), 32'(c >= 1 && c <= 3));
            check("t2_ldr_ack", 32'(ldr_ack), 32'(c == 4));
            check("t2_r_bit", 32'(r_bit), 0);
            if (c >= 1 && c <= 3) check("t2_mem_wdata", 32'(mem_wdata), 32'hBEEF);
            if (c == 1) check("t2_owner", 32'(owner), 1);
            next_cycle();
        end
        check("t2_ldr_rdata", 32'(ldr_rdata), 0);

        // Both held: CPU, loader, CPU at 5-cycle spacing
        idle_inputs();
        cpu_req = 1; cpu_addr = 16'h3010;
        ldr_req = 1; ldr_addr = 16'h3020;
        for (int c = 0; c < 18; c++) begin
            if (c == 15) begin cpu_req = 0; ldr_req = 0; end
            @(negedge clk);
            check("t3_r_bit", 32'(r_bit), 32'(c == 4 || c == 14));
            check("t3_ldr_ack", 32'(ldr_ack), 32'(c == 9));
            if (c == 1)  check("t3_owner_a", 32'(owner), 0);
            if (c == 6)  check("t3_owner_b", 32'(owner), 1);
            if (c == 11) check("t3_owner_c", 32'(owner), 0);
            next_cycle();
        end
        check("t3_cpu_rdata", 32'(cpu_rdata), 32'(init_val(16'h10)));
        check("t3_ldr_rdata", 32'(ldr_rdata), 32'(init_val(16'h20)));

        // Address change and request drop during ACCESS
        idle_inputs();
        cpu_req = 1; cpu_addr = 16'h3000;
        for (int c = 0; c < 7; c++) begin
            if (c == 2) begin cpu_addr = 16'h4000; cpu_req = 0; end
            @(negedge clk);
            check("t4_mem_en", 32'(mem_en), 32'(c >= 1 && c <= 3));
            check("t4_r_bit", 32'(r_bit), 32'(c == 4));
            if (c == 2 || c == 3) check("t4_mem_addr", 32'(mem_addr), 32'h3000);
            next_cycle();
        end

        // Async reset in the 2nd ACCESS cycle of a loader read
        idle_inputs();
        ldr_req = 1; ldr_addr = 16'h3002;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("t5_owner_pre", 32'(owner), 1);
        check("t5_busy_pre", 32'(busy), 1);
        next_cycle();
        #2 reset = 1'b0;
        #1;
        check("t5_mem_en", 32'(mem_en), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_owner", 32'(owner), 0);
        check("t5_cpu_rdata", 32'(cpu_rdata), 0);
        ldr_req = 0;
        @(posedge clk);
        #2 reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5_no_ack", 32'(ldr_ack), 0);
            check("t5_no_en", 32'(mem_en), 0);
            next_cycle();
        end
        cpu_req = 1; cpu_addr = 16'h3000;
        ldr_req = 1; ldr_addr = 16'h3003;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) begin cpu_req = 0; ldr_req = 0; end
            @(negedge clk);
            if (c == 1) check("t5_owner_post", 32'(owner), 0);
            check("t5_mem_en_post", 32'(mem_en), 32'(c >= 1 && c <= 3));
            check("t5_r_bit_post", 32'(r_bit), 32'(c == 4));
            check("t5_ldr_ack_post", 32'(ldr_ack), 0);
            next_cycle();
        end
        check("t5_cpu_rdata_post", 32'(cpu_rdata), 32'h1234);

        // Random traffic on a small address window to force read-after-write hits
        for (int c = 0; c < 4000; c++) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = {8'h30, 8'($urandom_range(0, 15))};
            cpu_wdata = 16'($urandom);
            ldr_req   = ($urandom_range(0, 2) != 0);
            ldr_we    = $urandom_range(0, 1) == 1;
            ldr_addr  = {8'h30, 8'($urandom_range(0, 15))};
            ldr_wdata = 16'($urandom);
            next_cycle();
        end
        idle_inputs();
        repeat (8) next_cycle();

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
